// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, FSM state type and font lookup for the FND scan controller
package fnd_pkg;

  localparam int MAX_DISPLAY = 9999;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_CONVERT
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; non-decimal nibbles render blank.
  function automatic logic [7:0] fnd_font(input logic [3:0] nib);
    case (nib)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      4'd9:    return FONT_9;
      default: return FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// rtl/fnd_bin2bcd.sv - iterative shift-add-3 binary to 4-digit BCD converter, one bit per cycle
module fnd_bin2bcd #(
  parameter int IN_BITS = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [IN_BITS-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_bcd
);

  localparam int CNT_W = $clog2(IN_BITS);

  logic [IN_BITS-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [15:0]        bcd_adj, bcd_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
      end
    end
    bcd_shift = (bcd_adj << 1) | {15'd0, bin_q[IN_BITS-1]};
  end

  // The result is taken combinationally on the final shift so the caller can load it that same edge.
  assign o_done = busy_q && (cnt_q == CNT_W'(IN_BITS - 1));
  assign o_busy = busy_q;
  assign o_bcd  = bcd_shift;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (i_start) begin
      bin_d  = i_bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bin_d = bin_q << 1;
      bcd_d = bcd_shift;
      cnt_d = cnt_q + CNT_W'(1);
      if (o_done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit FND scan controller with clamped BCD load; FND_LEADING_ZERO_BLANK_EN blanks leading zeros
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int CONV_BITS = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [CONV_BITS-1:0] i_value,
  output logic                 o_ready,
  input  logic                 i_en,
  output logic                 o_ovf,
  output logic [3:0]           o_digit,
  output logic [7:0]           o_font
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           digit_q, digit_d;
  logic [7:0]           font_q, font_d;
  logic                 conv_start, conv_busy, conv_done;
  logic [15:0]          conv_bcd;
  logic [CONV_BITS-1:0] load_value;
  logic                 over_range;
  logic                 pre_wrap;
  logic [3:0]           nib;
  logic                 lead_blank;

  assign over_range = i_value > CONV_BITS'(MAX_DISPLAY);
  assign load_value = over_range ? CONV_BITS'(MAX_DISPLAY) : i_value;

  fnd_bin2bcd #(
    .IN_BITS (CONV_BITS)
  ) u_bin2bcd (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (conv_start),
    .i_bin     (load_value),
    .o_busy    (conv_busy),
    .o_done    (conv_done),
    .o_bcd     (conv_bcd)
  );

  // The display register only changes on the final conversion edge, never mid-conversion.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          conv_start = 1'b1;
          ovf_d      = over_range;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_busy && conv_done) begin
          disp_d  = conv_bcd;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d    = pre_wrap ? idx_q + 2'd1 : idx_q;
    nib      = disp_q[{idx_q, 2'b00} +: 4];
`ifdef FND_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1:    lead_blank = (disp_q[15:4] == 12'd0);
      2'd2:    lead_blank = (disp_q[15:8] == 8'd0);
      2'd3:    lead_blank = (disp_q[15:12] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
`else
    lead_blank = 1'b0;
`endif
    digit_d = i_en ? ~(4'b0001 << idx_q) : 4'b1111;
    font_d  = (!i_en || lead_blank) ? FONT_BLANK : fnd_font(nib);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      digit_q <= 4'b1111;
      font_q  <= FONT_BLANK;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      digit_q <= digit_d;
      font_q  <= font_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_ovf   = ovf_q;
  assign o_digit = digit_q;
  assign o_font  = font_q;

endmodule
